// File: rtl/ps2_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// ps2_pkg : constants and types shared by the PS/2 receiver and its
//           keyboard-matrix consumer.                      Rev 1.0
// ------------------------------------------------------------------
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;

  localparam int PS2_KEY_W       = 11;
  localparam int PS2_KEY_STROBE  = 10;
  localparam int PS2_KEY_PRESSED = 9;
  localparam int PS2_KEY_EXT     = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  // Odd parity over data plus parity bit means the XOR of all nine is 1.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_frame_rx_if.sv
`default_nettype none
// ------------------------------------------------------------------
// ps2_frame_rx_if : keyboard line inputs and key-event outputs of the
//                   PS/2 frame receiver.                   Rev 1.0
// ------------------------------------------------------------------
interface ps2_frame_rx_if;
  import ps2_pkg::*;

  logic                 ps2_clk;
  logic                 ps2_data;
  logic [PS2_KEY_W-1:0] ps2_key;
  logic                 frame_err;

  modport master (output ps2_clk, ps2_data, input ps2_key, frame_err);
  modport slave  (input ps2_clk, ps2_data, output ps2_key, frame_err);

endinterface
`default_nettype wire

// File: rtl/ps2_filter.sv
`default_nettype none
// ------------------------------------------------------------------
// ps2_filter : 2-flop synchronizer, level glitch filter and one-cycle
//              falling-edge pulse for the PS/2 clock line.  Rev 1.0
// ------------------------------------------------------------------
module ps2_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic fall
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [1:0]       sync_q, sync_d;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fall_q, fall_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      cnt_q  <= '0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
      fall_q <= fall_d;
    end
  end

  // Any sample matching the current level restarts the run count.
  always_comb begin
    sync_d = {sync_q[0], din};
    filt_d = filt_q;
    cnt_d  = '0;
    fall_d = 1'b0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync_q[1];
        fall_d = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign fall = fall_q;

endmodule
`default_nettype wire

// File: rtl/ps2_frame_rx.sv
`default_nettype none
// ------------------------------------------------------------------
// ps2_frame_rx : PS/2 keyboard frame receiver producing toggle-strobed
//                key-event words with E0/F0 prefix tracking. Rev 1.0
// ------------------------------------------------------------------
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 6500
) (
  input  logic          clk,
  input  logic          reset,
  ps2_frame_rx_if.slave bus
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic                 clk_fall;
  logic                 data_bit;
  logic                 wd_expire;

  logic [1:0]           data_sync_q, data_sync_d;
  rx_state_e            state_q, state_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic                 parity_ok_q, parity_ok_d;
  logic [WD_W-1:0]      wdog_q, wdog_d;
  logic                 ext_q, ext_d;
  logic                 rel_q, rel_d;
  logic [PS2_KEY_W-1:0] key_q, key_d;
  logic                 err_q, err_d;

  ps2_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk  (clk),
    .reset(reset),
    .din  (bus.ps2_clk),
    .fall (clk_fall)
  );

  assign data_bit  = data_sync_q[1];
  assign wd_expire = (state_q != ST_IDLE) && (wdog_q == WD_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_sync_q <= 2'b11;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_ok_q <= 1'b0;
      wdog_q      <= '0;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      key_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      data_sync_q <= data_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_ok_q <= parity_ok_d;
      wdog_q      <= wdog_d;
      ext_q       <= ext_d;
      rel_q       <= rel_d;
      key_q       <= key_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    data_sync_d = {data_sync_q[0], bus.ps2_data};
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_ok_d = parity_ok_q;
    ext_d       = ext_q;
    rel_d       = rel_q;
    key_d       = key_q;
    err_d       = 1'b0;
    wdog_d      = (state_q != ST_IDLE) ? wdog_q + WD_W'(1) : '0;
    if (clk_fall) begin
      wdog_d = WD_W'(1);
    end

    // Watchdog expiry wins over a coincident fall; prefix flags survive it.
    if (wd_expire) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      shift_d   = '0;
      err_d     = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (clk_fall && !data_bit) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
            shift_d   = '0;
          end
        end
        ST_DATA: begin
          if (clk_fall) begin
            shift_d   = {data_bit, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = ST_PARITY;
            end
          end
        end
        ST_PARITY: begin
          if (clk_fall) begin
            parity_ok_d = odd_parity_ok(shift_q, data_bit);
            state_d     = ST_STOP;
          end
        end
        ST_STOP: begin
          if (clk_fall) begin
            state_d = ST_IDLE;
            if (parity_ok_q && data_bit) begin
              if (shift_q == PS2_PREFIX_EXT) begin
                ext_d = 1'b1;
              end else if (shift_q == PS2_PREFIX_REL) begin
                rel_d = 1'b1;
              end else begin
                key_d = {~key_q[PS2_KEY_STROBE], ~rel_q, ext_q, shift_q};
                ext_d = 1'b0;
                rel_d = 1'b0;
              end
            end else begin
              err_d = 1'b1;
              ext_d = 1'b0;
              rel_d = 1'b0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (state_d == ST_IDLE) begin
      wdog_d = '0;
    end
  end

  assign bus.ps2_key   = key_q;
  assign bus.frame_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_frame_rx.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_ps2_frame_rx : directed self-checking bench for ps2_frame_rx.
//                                                          Rev 1.0
// ------------------------------------------------------------------
module tb_ps2_frame_rx;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 300;
  localparam int HALF       = 20;
  // Negedges from driving ps2_clk low until a registered FSM reaction is visible:
  // 2 sync flops + FILTER_LEN filter samples give the fall pulse, +1 for the FSM.
  localparam int FSM_LAT    = FILTER_LEN + 3;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  int   err_seen;
  int   err_long;
  int   key_changes;
  logic err_prev;
  logic [10:0] key_prev;

  ps2_frame_rx_if bus_if ();

  ps2_frame_rx #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset) begin
      if (bus_if.frame_err) err_seen++;
      if (bus_if.frame_err && err_prev) err_long++;
      if (bus_if.ps2_key !== key_prev) key_changes++;
    end
    err_prev = bus_if.frame_err;
    key_prev = bus_if.ps2_key;
  end

  task automatic send_bit(input logic b, output int lat_key, output int lat_err);
    logic [10:0] k0;
    bus_if.ps2_data = b;
    repeat (HALF) @(negedge clk);
    bus_if.ps2_clk = 1'b0;
    k0 = bus_if.ps2_key;
    lat_key = 0;
    lat_err = 0;
    for (int i = 1; i <= HALF; i++) begin
      @(negedge clk);
      if (lat_key == 0 && bus_if.ps2_key !== k0) lat_key = i;
      if (lat_err == 0 && bus_if.frame_err === 1'b1) lat_err = i;
    end
    bus_if.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop,
                            output int lat_key, output int lat_err);
    logic par;
    int   lk, le;
    par = (~^b) ^ par_flip;
    send_bit(1'b0, lk, le);
    for (int i = 0; i < 8; i++) send_bit(b[i], lk, le);
    send_bit(par, lk, le);
    send_bit(stop, lat_key, lat_err);
    bus_if.ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus_if.ps2_clk  = 1'b1;
    bus_if.ps2_data = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (bus_if.ps2_key !== 11'h000) begin
      n_bad++; $display("FAIL reset_key: got %h want %h", bus_if.ps2_key, 11'h000);
    end
    n_cmp++;
    if (bus_if.frame_err !== 1'b0) begin
      n_bad++; $display("FAIL reset_err: got %b want 0", bus_if.frame_err);
    end
    reset = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (bus_if.ps2_key !== 11'h000) begin
      n_bad++; $display("FAIL post_reset_key: got %h want %h", bus_if.ps2_key, 11'h000);
    end
  endtask

  task automatic test_valid;
    int lk, le, e0;
    e0 = err_seen;
    send_frame(8'h1C, 1'b0, 1'b1, lk, le);
    n_cmp++;
    if (bus_if.ps2_key !== 11'h61C) begin
      n_bad++; $display("FAIL valid_1c_key: got %h want %h", bus_if.ps2_key, 11'h61C);
    end
    n_cmp++;
    if (lk != FSM_LAT) begin
      n_bad++; $display("FAIL valid_1c_latency: got %0d want %0d", lk, FSM_LAT);
    end
    n_cmp++;
    if (err_seen != e0) begin
      n_bad++; $display("FAIL valid_1c_err: got %0d want 0", err_seen - e0);
    end
  endtask

  task automatic test_release;
    int lk, le, c0;
    c0 = key_changes;
    send_frame(8'hF0, 1'b0, 1'b1, lk, le);
    n_cmp++;
    if (key_changes != c0 || bus_if.ps2_key !== 11'h61C) begin
      n_bad++; $display("FAIL f0_no_update: got %h (%0d changes) want %h (0)",
                        bus_if.ps2_key, key_changes - c0, 11'h61C);
    end
    send_frame(8'h1C, 1'b0, 1'b1, lk, le);
    n_cmp++;
    if (bus_if.ps2_key !== 11'h01C) begin
      n_bad++; $display("FAIL release_1c_key: got %h want %h", bus_if.ps2_key, 11'h01C);
    end
    n_cmp++;
    if (key_changes != c0 + 1) begin
      n_bad++; $display("FAIL release_updates: got %0d want 1", key_changes - c0);
    end
  endtask

  task automatic test_ext_release;
    int lk, le, c0;
    c0 = key_changes;
    send_frame(8'hE0, 1'b0, 1'b1, lk, le);
    send_frame(8'hF0, 1'b0, 1'b1, lk, le);
    send_frame(8'h75, 1'b0, 1'b1, lk, le);
    n_cmp++;
    if (bus_if.ps2_key[9:0] !== 10'h175) begin
      n_bad++; $display("FAIL ext_rel_code: got %h want %h", bus_if.ps2_key[9:0], 10'h175);
    end
    n_cmp++;
    if (bus_if.ps2_key[10] !== 1'b1) begin
      n_bad++; $display("FAIL ext_rel_strobe: got %b want 1", bus_if.ps2_key[10]);
    end
    n_cmp++;
    if (key_changes != c0 + 1) begin
      n_bad++; $display("FAIL ext_rel_updates: got %0d want 1", key_changes - c0);
    end
  endtask

  task automatic test_parity_err;
    int lk, le, e0;
    e0 = err_seen;
    send_frame(8'h1C, 1'b1, 1'b1, lk, le);
    n_cmp++;
    if (err_seen != e0 + 1) begin
      n_bad++; $display("FAIL parity_err_count: got %0d want 1", err_seen - e0);
    end
    n_cmp++;
    if (le != FSM_LAT) begin
      n_bad++; $display("FAIL parity_err_latency: got %0d want %0d", le, FSM_LAT);
    end
    n_cmp++;
    if (bus_if.ps2_key !== 11'h575) begin
      n_bad++; $display("FAIL parity_err_key: got %h want %h", bus_if.ps2_key, 11'h575);
    end
    n_cmp++;
    if (err_long != 0) begin
      n_bad++; $display("FAIL parity_err_width: got %0d long pulses want 0", err_long);
    end
    send_frame(8'h32, 1'b0, 1'b1, lk, le);
    n_cmp++;
    if (bus_if.ps2_key !== 11'h232) begin
      n_bad++; $display("FAIL after_err_32_key: got %h want %h", bus_if.ps2_key, 11'h232);
    end
  endtask

  task automatic test_stop_err;
    int lk, le, e0;
    send_frame(8'hF0, 1'b0, 1'b1, lk, le);
    e0 = err_seen;
    send_frame(8'h1C, 1'b0, 1'b0, lk, le);
    n_cmp++;
    if (err_seen != e0 + 1) begin
      n_bad++; $display("FAIL stop_err_count: got %0d want 1", err_seen - e0);
    end
    n_cmp++;
    if (bus_if.ps2_key !== 11'h232) begin
      n_bad++; $display("FAIL stop_err_key: got %h want %h", bus_if.ps2_key, 11'h232);
    end
    // Release flag must be gone, so this is a press.
    send_frame(8'h1C, 1'b0, 1'b1, lk, le);
    n_cmp++;
    if (bus_if.ps2_key !== 11'h61C) begin
      n_bad++; $display("FAIL stop_err_flags_cleared: got %h want %h", bus_if.ps2_key, 11'h61C);
    end
  endtask

  task automatic test_glitch_timeout;
    int lk, le, e0, c0, n;
    logic found;
    e0 = err_seen;
    c0 = key_changes;
    bus_if.ps2_clk = 1'b0;
    repeat (4) @(negedge clk);
    bus_if.ps2_clk = 1'b1;
    repeat (40) @(negedge clk);
    n_cmp++;
    if (err_seen != e0) begin
      n_bad++; $display("FAIL glitch_err: got %0d want 0", err_seen - e0);
    end
    n_cmp++;
    if (key_changes != c0) begin
      n_bad++; $display("FAIL glitch_key: got %0d changes want 0", key_changes - c0);
    end

    send_frame(8'hE0, 1'b0, 1'b1, lk, le);
    e0 = err_seen;
    send_bit(1'b0, lk, le);
    send_bit(1'b1, lk, le);
    send_bit(1'b0, lk, le);
    bus_if.ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    bus_if.ps2_clk = 1'b0;
    n = 0;
    found = 1'b0;
    while (!found && n < 2 * TIMEOUT) begin
      @(negedge clk);
      n++;
      if (n == HALF) bus_if.ps2_clk = 1'b1;
      if (bus_if.frame_err === 1'b1) found = 1'b1;
    end
    bus_if.ps2_clk = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (!found || n != FILTER_LEN + 2 + TIMEOUT) begin
      n_bad++; $display("FAIL timeout_latency: got %0d (seen %b) want %0d",
                        n, found, FILTER_LEN + 2 + TIMEOUT);
    end
    n_cmp++;
    if (err_seen != e0 + 1) begin
      n_bad++; $display("FAIL timeout_err_count: got %0d want 1", err_seen - e0);
    end
    n_cmp++;
    if (bus_if.ps2_key !== 11'h61C) begin
      n_bad++; $display("FAIL timeout_key: got %h want %h", bus_if.ps2_key, 11'h61C);
    end
    // E0 received before the aborted frame still applies.
    send_frame(8'h29, 1'b0, 1'b1, lk, le);
    n_cmp++;
    if (bus_if.ps2_key !== 11'h329) begin
      n_bad++; $display("FAIL after_timeout_29_key: got %h want %h", bus_if.ps2_key, 11'h329);
    end
  endtask

  task automatic test_mid_reset;
    int lk, le, e0;
    send_bit(1'b0, lk, le);
    send_bit(1'b1, lk, le);
    send_bit(1'b1, lk, le);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (bus_if.ps2_key !== 11'h000) begin
      n_bad++; $display("FAIL mid_reset_key: got %h want %h", bus_if.ps2_key, 11'h000);
    end
    n_cmp++;
    if (bus_if.frame_err !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset_err: got %b want 0", bus_if.frame_err);
    end
    bus_if.ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    e0 = err_seen;
    send_frame(8'h45, 1'b0, 1'b1, lk, le);
    n_cmp++;
    if (bus_if.ps2_key !== 11'h645) begin
      n_bad++; $display("FAIL after_reset_45_key: got %h want %h", bus_if.ps2_key, 11'h645);
    end
    n_cmp++;
    if (err_seen != e0 || err_long != 0) begin
      n_bad++; $display("FAIL after_reset_err: got %0d pulses, %0d long want 0, 0",
                        err_seen - e0, err_long);
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    err_seen    = 0;
    err_long    = 0;
    key_changes = 0;
    err_prev    = 1'b0;
    key_prev    = 11'h000;
    test_reset();
    test_valid();
    test_release();
    test_ext_release();
    test_parity_err();
    test_stop_err();
    test_glitch_timeout();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_frame_rx.md
PS2_FRAME_RX -- requirements
Module: ps2_frame_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive identical synchronized ps2_clk samples required to accept a level change.
REQ-002 SHALL have parameter TIMEOUT, default 6500: clk cycles (2 ms at 3.25 MHz) without a falling ps2_clk edge that abort a frame in progress.
REQ-003 SHALL have port clk, input, 1: the single clock, which is the CPU clock domain.
REQ-004 SHALL have port reset, input, 1: the reset, asynchronous and active-low.
REQ-005 SHALL have port ps2_clk, input, 1: PS/2 clock from the keyboard, asynchronous, idle high.
REQ-006 SHALL have port ps2_data, input, 1: PS/2 data from the keyboard, asynchronous, idle high.
REQ-007 SHALL have port ps2_key, output, 11: the key event word {strobe, pressed, extended, code[7:0]}.
REQ-008 SHALL have port frame_err, output, 1: one-cycle pulse on a parity, stop-bit or timeout error.

Function
REQ-009 SHALL pass ps2_clk and ps2_data through 2-flop synchronizers before any use.
REQ-010 SHALL change the filtered clock level only after FILTER_LEN consecutive equal synchronized samples that differ from the current filtered level.
REQ-011 SHALL produce a one-cycle fall pulse on each filtered high-to-low transition, with the synchronized ps2_data sampled in that same cycle.
REQ-012 SHALL implement an FSM with states IDLE, DATA, PARITY, STOP.
REQ-013 SHALL, in IDLE on a fall with data=0, load a bit counter with 0, go to DATA, and ignore a fall with data=1 while staying in IDLE.
REQ-014 SHALL, in DATA, shift in the sampled bit LSB first on each fall, and go to PARITY after the 8th bit.
REQ-015 SHALL, in PARITY, latch parity_ok = (XOR of the 8 data bits and the parity bit) == 1 (odd parity) on the fall, then go to STOP.
REQ-016 SHALL, in STOP on a fall, go to IDLE and accept the byte iff parity_ok and data=1; otherwise it pulses frame_err for 1 cycle, discards the byte and clears both prefix flags.
REQ-017 SHALL set ext_flag on an accepted byte 0xE0, with no ps2_key update.
REQ-018 SHALL set rel_flag on an accepted byte 0xF0, with no ps2_key update.
REQ-019 SHALL, on any other accepted byte b, register ps2_key <= {~ps2_key[10], ~rel_flag, ext_flag, b} in the cycle after the stop-bit fall, and clear both flags in that same cycle.
REQ-020 SHALL publish 0xE1 and all other codes as ordinary codes, with no special Pause handling.
REQ-021 SHALL, in any non-IDLE state, run a watchdog counter that resets on every fall; on reaching TIMEOUT the FSM goes to IDLE, discards partial data and pulses frame_err, and the prefix flags are kept.
REQ-022 SHALL treat a fall in the same cycle the watchdog expires as a timeout, so the abort has priority.
REQ-023 SHALL produce frame_err pulses that are exactly 1 cycle long, never coincide with a ps2_key update, and occur at most once per frame.
REQ-024 SHALL make ps2_key[10] toggle exactly once per published event, so consumers detect an event by a change of bit 10.

Reset
REQ-025 SHALL, while reset=0, asynchronously force: state=IDLE, ps2_key=11'h000, frame_err=0, ext_flag=rel_flag=0, shift/bit counter/watchdog=0.
REQ-026 SHALL, while reset=0, asynchronously force the synchronizer and filter registers to 1 (the idle line level).
REQ-027 SHALL discard any frame in progress when reset is asserted mid-frame; after release, reception resumes at the next start bit.

Structure
REQ-028 SHALL place the constants PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_REL=8'hF0 and the ps2_key field bit positions (STROBE=10, PRESSED=9, EXT=8) in shared package ps2_pkg, for use by the keyboard-matrix consumer.
REQ-029 SHALL contain one sub-module, ps2_filter (synchronizer plus glitch filter plus fall detect), instantiated once for ps2_clk; ps2_data uses only a 2-flop synchronizer.

Verification
REQ-030 SHALL cover: valid frame 0x1C with parity 0 and stop 1 -> ps2_key=11'h61C (strobe 1, pressed 1, ext 0), 1 cycle after the stop fall.
REQ-031 SHALL cover: F0 then 1C frames -> a single update, ps2_key={~prev strobe,0,0,8'h1C}, with no update after F0.
REQ-032 SHALL cover: E0 F0 75 frames -> ps2_key[9:0]=10'h175 (released, extended, 0x75), with the strobe toggled once.
REQ-033 SHALL cover: frame 0x1C with a wrong parity bit -> frame_err 1-cycle pulse and ps2_key unchanged; the next valid 0x32 then publishes 0x32 with pressed=1 and ext=0.
REQ-034 SHALL cover: a 4-cycle low glitch on ps2_clk while idle -> no state change; a start bit plus 3 data bits followed by silence -> frame_err exactly TIMEOUT cycles after the last fall, then a clean 0x29 frame is received correctly.
REQ-035 SHALL cover: reset=0 asserted mid-DATA -> immediate IDLE and ps2_key=0; after release, frame 0x45 -> ps2_key=11'h645.
